// File: rtl/dma_frame_sched.sv
// Frame-buffer ring scheduler for the pixel-capture DMA: starts one transfer per sensor
// frame into the next free buffer and hands filled buffers to the consumer in order.
module dma_frame_sched #(
    parameter int          NBUF   = 4,
    parameter logic [15:0] BASE0  = 16'h0000,
    parameter logic [15:0] STRIDE = 16'h1000,
    localparam int         IDXW   = $clog2(NBUF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [15:0]     frame_len,
    input  logic            frame_sync,
    output logic            dma_start,
    output logic [15:0]     dma_base,
    output logic [15:0]     dma_len,
    input  logic            dma_done,
    output logic            rdy_valid,
    output logic [IDXW-1:0] rdy_idx,
    output logic [15:0]     rdy_base,
    input  logic            buf_release,
    output logic            busy,
    output logic [15:0]     frames_done,
    output logic [15:0]     frames_dropped
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [IDXW:0] FULL = (IDXW+1)'(NBUF);

    state_t          state_q, state_d;
    logic [IDXW-1:0] wr_idx_q, wr_idx_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d;
    logic [IDXW:0]   fill_q, fill_d;
    logic            dma_start_q, dma_start_d;
    logic [15:0]     dma_base_q, dma_base_d;
    logic [15:0]     dma_len_q, dma_len_d;
    logic            rdy_valid_q;
    logic [IDXW-1:0] rdy_idx_q;
    logic [15:0]     rdy_base_q;
    logic [15:0]     frames_done_q, frames_done_d;
    logic [15:0]     frames_dropped_q, frames_dropped_d;
    logic            drop;
    logic            fill_inc;
    logic            release_ok;

    function automatic logic [15:0] base_of(input logic [IDXW-1:0] idx);
        logic [15:0] idx16;
        idx16 = 16'(idx);
        return BASE0 + idx16 * STRIDE;
    endfunction

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        dma_start_d   = 1'b0;
        dma_base_d    = dma_base_q;
        dma_len_d     = dma_len_q;
        frames_done_d = frames_done_q;
        drop          = 1'b0;
        fill_inc      = 1'b0;
        // rdy_valid_q always mirrors fill_q != 0, so this never underflows fill
        release_ok    = buf_release & rdy_valid_q;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (frame_sync) begin
                    // Full-ring test uses the fill before any same-cycle release
                    if (fill_q != FULL && frame_len != 16'h0000) begin
                        dma_start_d = 1'b1;
                        dma_base_d  = base_of(wr_idx_q);
                        dma_len_d   = frame_len;
                        state_d     = RUN;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            RUN: begin
                if (frame_sync) drop = 1'b1;
                if (dma_done) begin
                    wr_idx_d      = wr_idx_q + 1'b1;
                    fill_inc      = 1'b1;
                    frames_done_d = frames_done_q + 16'd1;
                    state_d       = enable ? WAIT_SYNC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_ok) rd_idx_d = rd_idx_q + 1'b1;

        fill_d = fill_q + (IDXW+1)'(fill_inc) - (IDXW+1)'(release_ok);

        frames_dropped_d = frames_dropped_q;
        if (drop && frames_dropped_q != 16'hFFFF) frames_dropped_d = frames_dropped_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            wr_idx_q         <= '0;
            rd_idx_q         <= '0;
            fill_q           <= '0;
            dma_start_q      <= 1'b0;
            dma_base_q       <= BASE0;
            dma_len_q        <= 16'h0000;
            rdy_valid_q      <= 1'b0;
            rdy_idx_q        <= '0;
            rdy_base_q       <= BASE0;
            frames_done_q    <= 16'h0000;
            frames_dropped_q <= 16'h0000;
        end else begin
            state_q          <= state_d;
            wr_idx_q         <= wr_idx_d;
            rd_idx_q         <= rd_idx_d;
            fill_q           <= fill_d;
            dma_start_q      <= dma_start_d;
            dma_base_q       <= dma_base_d;
            dma_len_q        <= dma_len_d;
            // Consumer view is registered from next-state so it tracks fill_q/rd_idx_q exactly
            rdy_valid_q      <= (fill_d != '0);
            rdy_idx_q        <= rd_idx_d;
            rdy_base_q       <= base_of(rd_idx_d);
            frames_done_q    <= frames_done_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign dma_start      = dma_start_q;
    assign dma_base       = dma_base_q;
    assign dma_len        = dma_len_q;
    assign rdy_valid      = rdy_valid_q;
    assign rdy_idx        = rdy_idx_q;
    assign rdy_base       = rdy_base_q;
    assign busy           = (state_q == RUN);
    assign frames_done    = frames_done_q;
    assign frames_dropped = frames_dropped_q;

endmodule
